// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the pipelined core.
// Resolves load-use stalls and taken-branch flushes, and serialises stores to
// the UART TX register by issuing a one-cycle start and freezing the pipeline
// until the transmitter has accepted and finished the byte.
// Optional build macro: PIPE_HAZARD_CTRL_PERF_EN adds saturating stall/flush
// performance counters and their output ports.
module pipe_hazard_ctrl #(
  parameter int REG_W       = 5,
  parameter int ARM_TIMEOUT = 16
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  , parameter int CNT_W     = 16
`endif
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [REG_W-1:0] rs1_d,
  input  logic [REG_W-1:0] rs2_d,
  input  logic [REG_W-1:0] rd_e,
  input  logic             memread_e,
  input  logic             br_taken_e,
  input  logic             uart_wr_m,
  input  logic             uart_busy,
  output logic             stall_f,
  output logic             stall_d,
  output logic             flush_d,
  output logic             flush_e,
  output logic             stall_all,
  output logic             uart_start,
  output logic             uart_err,
  output logic [1:0]       state
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  , output logic [CNT_W-1:0] stall_cnt
  , output logic [CNT_W-1:0] flush_cnt
`endif
);

  typedef enum logic [1:0] {
    RUN  = 2'b00,
    ARM  = 2'b01,
    BUSY = 2'b10,
    ILL  = 2'b11
  } state_t;

  localparam int             TMR_W    = $clog2(ARM_TIMEOUT);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(ARM_TIMEOUT - 1);

  state_t           state_q;
  state_t           state_nxt;
  logic [TMR_W-1:0] timer;
  logic             load_use;
  logic             arm_expired;

  assign state = state_q;

  // Load in execute whose (non-zero) destination feeds the decode instruction.
  assign load_use = memread_e && (rd_e != '0) &&
                    ((rd_e == rs1_d) || (rd_e == rs2_d));

  // Last ARM cycle with no sign of the transmitter going busy.
  assign arm_expired = (state_q == ARM) && !uart_busy && (timer == TMR_LAST);

  // State register.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create order-dependent races.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= RUN;
    else        state_q <= state_nxt;
  end

  // ARM wait timer (restarts whenever ARM is entered) and sticky error flag.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer    <= '0;
      uart_err <= 1'b0;
    end else begin
      timer <= (state_q == ARM) ? timer + 1'b1 : '0;
      if (arm_expired) uart_err <= 1'b1;
    end
  end

  // Next-state logic.
  always_comb begin
    // NOTE: default assignment first so no path leaves the signal unassigned,
    // which would otherwise infer a latch.
    state_nxt = state_q;
    unique case (state_q)
      RUN:  if (uart_wr_m && !uart_busy) state_nxt = ARM;
      ARM:  begin
              if (uart_busy)        state_nxt = BUSY;
              else if (arm_expired) state_nxt = RUN;
            end
      BUSY: if (!uart_busy) state_nxt = RUN;
      ILL:  state_nxt = RUN;
    endcase
  end

  // Mealy outputs; held low while reset is asserted.
  always_comb begin
    stall_f    = 1'b0;
    stall_d    = 1'b0;
    flush_d    = 1'b0;
    flush_e    = 1'b0;
    stall_all  = 1'b0;
    uart_start = 1'b0;
    if (reset) begin
      unique case (state_q)
        RUN: begin
          if (uart_wr_m) begin
            // Freeze while the UART is busy; start only when it is idle.
            stall_all  = 1'b1;
            uart_start = !uart_busy;
          end else if (br_taken_e) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
          end else if (load_use) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
          end
        end
        ARM, BUSY: stall_all = 1'b1;
        ILL:       ;
      endcase
    end
  end

`ifdef PIPE_HAZARD_CTRL_PERF_EN
  // Saturating performance counters.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if ((stall_f || stall_all) && !(&stall_cnt)) stall_cnt <= stall_cnt + 1'b1;
      if (flush_d && !(&flush_cnt))                flush_cnt <= flush_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed self-checking bench for pipe_hazard_ctrl.
// Inputs change on the falling edge; combinational outputs are sampled 1ns
// later, well clear of the rising edge.
module tb_pipe_hazard_ctrl;

  localparam int REG_W = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic [REG_W-1:0] rs1_d, rs2_d, rd_e;
  logic             memread_e, br_taken_e, uart_wr_m, uart_busy;
  logic             stall_f, stall_d, flush_d, flush_e, stall_all;
  logic             uart_start, uart_err;
  logic [1:0]       state;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
  logic [15:0]      stall_cnt, flush_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REG_W(REG_W), .ARM_TIMEOUT(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .rs1_d      (rs1_d),
    .rs2_d      (rs2_d),
    .rd_e       (rd_e),
    .memread_e  (memread_e),
    .br_taken_e (br_taken_e),
    .uart_wr_m  (uart_wr_m),
    .uart_busy  (uart_busy),
    .stall_f    (stall_f),
    .stall_d    (stall_d),
    .flush_d    (flush_d),
    .flush_e    (flush_e),
    .stall_all  (stall_all),
    .uart_start (uart_start),
    .uart_err   (uart_err),
    .state      (state)
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    , .stall_cnt (stall_cnt)
    , .flush_cnt (flush_cnt)
`endif
  );

  // {stall_f, stall_d, flush_d, flush_e, stall_all, uart_start, uart_err, state}
  logic [8:0] outs;
  assign outs = {stall_f, stall_d, flush_d, flush_e, stall_all,
                 uart_start, uart_err, state};

  task automatic check(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    rs1_d = '0; rs2_d = '0; rd_e = '0;
    memread_e = 1'b0; br_taken_e = 1'b0; uart_wr_m = 1'b0; uart_busy = 1'b0;
  endtask

  initial begin
    clear_inputs();
    reset = 1'b0;
    #7;
    check("reset_outs", 16'(outs), 16'b000000000);
    @(negedge clk); reset = 1'b1;
    repeat (5) @(negedge clk);
    #1 check("idle_5cyc", 16'(outs), 16'b000000000);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    check("stall_cnt_idle", stall_cnt, 16'd0);
`endif

    // Load-use on rs1.
    @(negedge clk); memread_e = 1'b1; rd_e = 5'd5; rs1_d = 5'd5;
    #1 check("lu_rs1", 16'(outs), 16'b110100000);
    // Load to x0 never stalls.
    @(negedge clk); rd_e = 5'd0; rs1_d = 5'd0;
    #1 check("lu_x0", 16'(outs), 16'b000000000);
    // Matching regs but not a load.
    @(negedge clk); memread_e = 1'b0; rd_e = 5'd7; rs2_d = 5'd7;
    #1 check("no_load", 16'(outs), 16'b000000000);
    // Load-use on rs2.
    @(negedge clk); memread_e = 1'b1; rd_e = 5'd9; rs1_d = 5'd1; rs2_d = 5'd9;
    #1 check("lu_rs2", 16'(outs), 16'b110100000);
    // Branch beats load-use.
    @(negedge clk); rd_e = 5'd3; rs2_d = 5'd3; br_taken_e = 1'b1;
    #1 check("br_over_lu", 16'(outs), 16'b001100000);
    // Branch alone.
    @(negedge clk); clear_inputs(); br_taken_e = 1'b1;
    #1 check("br_only", 16'(outs), 16'b001100000);

    // UART store: start cycle.
    @(negedge clk); clear_inputs(); uart_wr_m = 1'b1;
    #1 check("tx_start", 16'(outs), 16'b000011000);
    // ARM, with a branch and load-use present: both must be suppressed.
    @(negedge clk); br_taken_e = 1'b1; memread_e = 1'b1; rd_e = 5'd4; rs1_d = 5'd4;
    #1 check("arm_frozen", 16'(outs), 16'b000010001);
    // Busy rises two cycles after start, still in ARM.
    @(negedge clk); br_taken_e = 1'b0; memread_e = 1'b0; uart_busy = 1'b1;
    #1 check("arm_busy", 16'(outs), 16'b000010001);
    // Nine more busy cycles in BUSY (ten busy cycles total).
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      #1 check($sformatf("busy_%0d", i), 16'(outs), 16'b000010010);
    end
    // Busy falls: exit cycle still frozen.
    @(negedge clk); uart_busy = 1'b0;
    #1 check("busy_exit", 16'(outs), 16'b000010010);
    // Released; the store has advanced.
    @(negedge clk); uart_wr_m = 1'b0;
    #1 check("tx_release", 16'(outs), 16'b000000000);
    @(negedge clk);
    #1 check("tx_idle", 16'(outs), 16'b000000000);

    // Timeout: busy never rises.
    @(negedge clk); uart_wr_m = 1'b1;
    #1 check("to_start", 16'(outs), 16'b000011000);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      #1 check($sformatf("to_arm_%0d", i), 16'(outs), 16'b000010001);
    end
    @(negedge clk); uart_wr_m = 1'b0;
    #1 check("to_err", 16'(outs), 16'b000000100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      #1 check($sformatf("to_hold_%0d", i), 16'(outs), 16'b000000100);
    end

    // Reset mid-BUSY.
    @(negedge clk); uart_wr_m = 1'b1;
    #1 check("r_start", 16'(outs), 16'b000011100);
    @(negedge clk); uart_busy = 1'b1;
    #1 check("r_arm", 16'(outs), 16'b000010101);
    @(negedge clk);
    #1 check("r_busy", 16'(outs), 16'b000010110);
    #1 reset = 1'b0;
    #1 check("r_async", 16'(outs), 16'b000000000);
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    check("r_stall_cnt", stall_cnt, 16'd0);
    check("r_flush_cnt", flush_cnt, 16'd0);
`endif
    @(negedge clk);
    #1 check("r_held", 16'(outs), 16'b000000000);
    clear_inputs(); reset = 1'b1;
    @(negedge clk);
    #1 check("r_after", 16'(outs), 16'b000000000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
